// File: rtl/udma_stream_packer_if.sv
// Handshake bundle between a uDMA RX stream port, the packer, and the packed-word consumer.
// The slave modport is the packer's view; the master modport is the surrounding environment's view.
interface udma_stream_packer_if;
  logic [31:0] in_data_i;
  logic [1:0]  in_datasize_i;
  logic        in_valid_i;
  logic        in_sot_i;
  logic        in_eot_i;
  logic        in_ready_o;
  logic [31:0] out_data_o;
  logic [3:0]  out_be_o;
  logic        out_last_o;
  logic        out_valid_o;
  logic        out_ready_i;

  modport slave (
    input  in_data_i, in_datasize_i, in_valid_i, in_sot_i, in_eot_i,
    output in_ready_o,
    output out_data_o, out_be_o, out_last_o, out_valid_o,
    input  out_ready_i
  );

  modport master (
    output in_data_i, in_datasize_i, in_valid_i, in_sot_i, in_eot_i,
    input  in_ready_o,
    input  out_data_o, out_be_o, out_last_o, out_valid_o,
    output out_ready_i
  );
endinterface

// File: rtl/udma_stream_packer.sv
// Packs byte/halfword/word uDMA stream beats little-endian into 32-bit words with
// byte enables and a last flag, buffered in a small output FIFO.
module udma_stream_packer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 3
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 clr_i,
  udma_stream_packer_if.slave  bus,
  output logic [CNT_WIDTH-1:0] fifo_count_o,
  output logic                 drop_o
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic {FILL = 1'b0, FLUSH = 1'b1} state_e;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  be;
    logic        last;
  } entry_t;

  function automatic logic [3:0] be_mask(input logic [2:0] n);
    case (n)
      3'd0:    be_mask = 4'b0000;
      3'd1:    be_mask = 4'b0001;
      3'd2:    be_mask = 4'b0011;
      3'd3:    be_mask = 4'b0111;
      default: be_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [23:0] hold_mask(input logic [1:0] f);
    case (f)
      2'd0:    hold_mask = 24'h000000;
      2'd1:    hold_mask = 24'h0000FF;
      2'd2:    hold_mask = 24'h00FFFF;
      default: hold_mask = 24'hFFFFFF;
    endcase
  endfunction

  state_e               state_q, state_d;
  logic [23:0]          hold_q, hold_d;
  logic [1:0]           fill_q, fill_d;
  logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 drop_q, drop_d;
  entry_t               mem_q [FIFO_DEPTH];
  entry_t               push_entry_s, head_s;
  logic                 push_s, pop_s, full_s, empty_s, accept_s, in_ready_s;
  logic [1:0]           fill_eff_s;
  logic [2:0]           nbytes_s, total_s;
  logic [31:0]          in_bytes_s;
  logic [23:0]          hold_keep_s;
  logic [55:0]          combined_s;

  assign full_s     = (count_q == CNT_WIDTH'(FIFO_DEPTH));
  assign empty_s    = (count_q == {CNT_WIDTH{1'b0}});
  assign in_ready_s = (state_q == FILL) && !full_s;
  assign accept_s   = bus.in_valid_i && in_ready_s;
  assign pop_s      = !empty_s && bus.out_ready_i;

  // Beat decode: size the incoming bytes and stack them above the live held bytes.
  always_comb begin
    case (bus.in_datasize_i)
      2'b00: begin
        nbytes_s   = 3'd1;
        in_bytes_s = {24'h000000, bus.in_data_i[7:0]};
      end
      2'b01: begin
        nbytes_s   = 3'd2;
        in_bytes_s = {16'h0000, bus.in_data_i[15:0]};
      end
      default: begin
        nbytes_s   = 3'd4;
        in_bytes_s = bus.in_data_i;
      end
    endcase
    if (bus.in_sot_i) begin
      fill_eff_s = 2'd0;
    end else begin
      fill_eff_s = fill_q;
    end
    hold_keep_s = hold_q & hold_mask(fill_eff_s);
    combined_s  = ({24'h000000, in_bytes_s} << {fill_eff_s, 3'b000}) | {32'h00000000, hold_keep_s};
    total_s     = {1'b0, fill_eff_s} + nbytes_s;
  end

  // Packing FSM next-state; for T>=4 the new fill is T-4, i.e. the low two bits of T.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    fill_d       = fill_q;
    drop_d       = 1'b0;
    push_s       = 1'b0;
    push_entry_s = '0;
    if (clr_i) begin
      state_d = FILL;
      hold_d  = 24'h000000;
      fill_d  = 2'd0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept_s) begin
            drop_d = bus.in_sot_i && (fill_q != 2'd0);
            if (total_s < 3'd4) begin
              if (bus.in_eot_i) begin
                push_s       = 1'b1;
                push_entry_s = '{data: combined_s[31:0], be: be_mask(total_s), last: 1'b1};
                fill_d       = 2'd0;
                hold_d       = 24'h000000;
              end else begin
                fill_d = total_s[1:0];
                hold_d = combined_s[23:0];
              end
            end else begin
              push_s       = 1'b1;
              push_entry_s = '{data: combined_s[31:0], be: 4'b1111, last: 1'b0};
              fill_d       = total_s[1:0];
              hold_d       = combined_s[55:32];
              if (bus.in_eot_i) begin
                if (total_s == 3'd4) begin
                  push_entry_s.last = 1'b1;
                end else begin
                  state_d = FLUSH;
                end
              end else begin
                state_d = FILL;
              end
            end
          end else begin
            state_d = FILL;
          end
        end
        FLUSH: begin
          if (!full_s) begin
            push_s       = 1'b1;
            push_entry_s = '{data: {8'h00, hold_q}, be: be_mask({1'b0, fill_q}), last: 1'b1};
            fill_d       = 2'd0;
            hold_d       = 24'h000000;
            state_d      = FILL;
          end else begin
            state_d = FLUSH;
          end
        end
        default: begin
          state_d = FILL;
          fill_d  = 2'd0;
        end
      endcase
    end
  end

  // FIFO pointer and occupancy bookkeeping; pushes only ever occur when not full.
  always_comb begin
    if (clr_i) begin
      wptr_d  = {AW{1'b0}};
      rptr_d  = {AW{1'b0}};
      count_d = {CNT_WIDTH{1'b0}};
    end else begin
      wptr_d  = wptr_q + {{(AW-1){1'b0}}, push_s};
      rptr_d  = rptr_q + {{(AW-1){1'b0}}, pop_s};
      count_d = count_q + {{(CNT_WIDTH-1){1'b0}}, push_s} - {{(CNT_WIDTH-1){1'b0}}, pop_s};
    end
  end

  // Control and datapath state registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= FILL;
      hold_q  <= 24'h000000;
      fill_q  <= 2'd0;
      wptr_q  <= {AW{1'b0}};
      rptr_q  <= {AW{1'b0}};
      count_q <= {CNT_WIDTH{1'b0}};
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      fill_q  <= fill_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  // FIFO storage is deliberately left unreset; validity comes from count_q.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wptr_q] <= push_entry_s;
    end
  end

  assign head_s          = mem_q[rptr_q];
  assign bus.in_ready_o  = in_ready_s;
  assign bus.out_valid_o = !empty_s;
  assign bus.out_data_o  = empty_s ? 32'h00000000 : head_s.data;
  assign bus.out_be_o    = empty_s ? 4'b0000 : head_s.be;
  assign bus.out_last_o  = empty_s ? 1'b0 : head_s.last;
  assign fifo_count_o    = count_q;
  assign drop_o          = drop_q;
endmodule
